// File: rtl/conv_seq_ctrl.sv
// rtl/conv_seq_ctrl.sv - convolution sequencer: walks X/F read addresses, strobes the
// accumulator and hands each y[j] out on a valid/ready handshake.
module conv_seq_ctrl #(
  parameter int X_SIZE   = 8,
  parameter int F_SIZE   = 4,
  parameter int X_ADDR_W = (X_SIZE > 1) ? $clog2(X_SIZE) : 1,
  parameter int F_ADDR_W = (F_SIZE > 1) ? $clog2(F_SIZE) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                conv_start,
  input  logic                m_ready_y,
  output logic [X_ADDR_W-1:0] xmem_rd_addr,
  output logic [F_ADDR_W-1:0] fmem_rd_addr,
  output logic                rd_own,
  output logic                clr_accum,
  output logic                en_accum,
  output logic                m_valid_y,
  output logic                conv_done,
  output logic                busy
);

  localparam int N_OUT = X_SIZE - F_SIZE + 1;
  localparam logic [X_ADDR_W-1:0] J_LAST = X_ADDR_W'(N_OUT - 1);
  localparam logic [F_ADDR_W-1:0] K_LAST = F_ADDR_W'(F_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_OUT,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [X_ADDR_W-1:0] j;
  logic [X_ADDR_W-1:0] j_nxt;
  logic [F_ADDR_W-1:0] k;
  logic [F_ADDR_W-1:0] k_nxt;
  logic                en_q;
  logic                done_q;

  // en_q trails each FETCH cycle by one, matching the synchronous memory read latency
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      j      <= '0;
      k      <= '0;
      en_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      j      <= j_nxt;
      k      <= k_nxt;
      en_q   <= (state == S_FETCH);
      done_q <= (state == S_DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    j_nxt     = j;
    k_nxt     = k;
    rd_own    = 1'b0;
    clr_accum = 1'b0;
    m_valid_y = 1'b0;
    conv_done = 1'b0;
    case (state)
      S_IDLE: begin
        // a start level still high right after DONE belongs to the previous run
        if (conv_start && !done_q) begin
          j_nxt     = '0;
          k_nxt     = '0;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        rd_own    = 1'b1;
        clr_accum = (k == '0);
        if (k == K_LAST) begin
          k_nxt     = '0;
          state_nxt = S_DRAIN;
        end else begin
          k_nxt = k + 1'b1;
        end
      end
      S_DRAIN: begin
        rd_own    = 1'b1;
        state_nxt = S_OUT;
      end
      S_OUT: begin
        rd_own    = 1'b1;
        m_valid_y = 1'b1;
        if (m_ready_y) begin
          if (j == J_LAST) begin
            state_nxt = S_DONE;
          end else begin
            j_nxt     = j + 1'b1;
            k_nxt     = '0;
            state_nxt = S_FETCH;
          end
        end
      end
      S_DONE: begin
        conv_done = 1'b1;
        j_nxt     = '0;
        k_nxt     = '0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign en_accum     = en_q;
  assign busy         = (state != S_IDLE);
  assign xmem_rd_addr = j + X_ADDR_W'(k);
  assign fmem_rd_addr = k;

endmodule
